// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall sequencer.
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } hz_state_e;

  localparam int unsigned REG_W_DEF   = 5;
  localparam int unsigned MDU_LAT_DEF = 4;
  localparam logic [4:0]  ZERO_REG    = 5'd0;

  // Pipeline control bundle driven by the sequencer each cycle
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_flush;
    logic exmem_flush;
    logic mdu_busy;
    logic mdu_done;
  } hz_ctrl_t;

endpackage

// File: rtl/mdu_wait_counter.sv
// Down-counter tracking the remaining frozen cycles of an MDU op in EX.
module mdu_wait_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard and stall sequencer: load-use stalls, taken-branch flushes, MDU freeze.
// Define HAZARD_PERF_EN to add stall/flush performance counters.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int unsigned MDU_LAT = MDU_LAT_DEF,
  parameter int unsigned REG_W   = REG_W_DEF,
  parameter int unsigned CNT_W   = $clog2(MDU_LAT)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             idex_memread_i,
  input  logic [REG_W-1:0] idex_rt_i,
  input  logic             ex_branch_taken_i,
  input  logic             ex_mdu_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_write_o,
  output logic             idex_flush_o,
  output logic             exmem_flush_o,
  output logic             mdu_busy_o,
  output logic             mdu_done_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]      perf_stall_cnt_o,
  output logic [31:0]      perf_flush_cnt_o
`endif
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MDU_LAT - 2);

  hz_state_e state_q;
  hz_state_e state_d;
  hz_ctrl_t  ctl;
  logic      cnt_zero;
  logic      cnt_load;
  logic      cnt_dec;
  logic      load_use;

  // r0 is never a real destination, so a load "into" it cannot create a hazard
  assign load_use = idex_memread_i
                 && (idex_rt_i != REG_W'(ZERO_REG))
                 && ((idex_rt_i == id_rs_i) || (id_uses_rt_i && (idex_rt_i == id_rt_i)));

  mdu_wait_counter #(
    .CNT_W (CNT_W)
  ) u_mdu_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (cnt_load),
    .load_val_i (CNT_INIT),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    ctl            = '0;
    ctl.pc_write   = 1'b1;
    ctl.ifid_write = 1'b1;
    ctl.idex_write = 1'b1;
    state_d        = state_q;
    cnt_load       = 1'b0;
    cnt_dec        = 1'b0;

    if ((state_q == MDU_WAIT) && !cnt_zero) begin
      ctl.pc_write    = 1'b0;
      ctl.ifid_write  = 1'b0;
      ctl.idex_write  = 1'b0;
      ctl.exmem_flush = 1'b1;
      ctl.mdu_busy    = 1'b1;
      cnt_dec         = 1'b1;
    end else begin
      // Release cycle: the held op must not re-trigger the freeze
      if (state_q == MDU_WAIT) begin
        ctl.mdu_busy = 1'b1;
        ctl.mdu_done = 1'b1;
        state_d      = RUN;
      end
      if (ex_branch_taken_i) begin
        ctl.ifid_flush = 1'b1;
        ctl.idex_flush = 1'b1;
      end else if (ex_mdu_i && (state_q == RUN)) begin
        ctl.pc_write    = 1'b0;
        ctl.ifid_write  = 1'b0;
        ctl.idex_write  = 1'b0;
        ctl.exmem_flush = 1'b1;
        state_d         = MDU_WAIT;
        cnt_load        = 1'b1;
      end else if (load_use) begin
        ctl.pc_write   = 1'b0;
        ctl.ifid_write = 1'b0;
        ctl.idex_flush = 1'b1;
      end
    end

    if (rst_i) begin
      ctl = '0;
    end
  end

  assign pc_write_o    = ctl.pc_write;
  assign ifid_write_o  = ctl.ifid_write;
  assign ifid_flush_o  = ctl.ifid_flush;
  assign idex_write_o  = ctl.idex_write;
  assign idex_flush_o  = ctl.idex_flush;
  assign exmem_flush_o = ctl.exmem_flush;
  assign mdu_busy_o    = ctl.mdu_busy;
  assign mdu_done_o    = ctl.mdu_done;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (!ctl.pc_write) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (ctl.ifid_flush) begin
        perf_flush_q <= perf_flush_q + 32'd1;
      end
    end
  end

  assign perf_stall_cnt_o = perf_stall_q;
  assign perf_flush_cnt_o = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: vector table, directed MDU/reset sequences, random vs model.
module tb_hazard_ctrl_unit;

  localparam int unsigned MDU_LAT = 4;

  // Output vector order: pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_flush, mdu_busy, mdu_done
  localparam logic [7:0] O_DEF   = 8'b1101_0000;
  localparam logic [7:0] O_LU    = 8'b0001_1000;
  localparam logic [7:0] O_BR    = 8'b1111_1000;
  localparam logic [7:0] O_ENT   = 8'b0000_0100;
  localparam logic [7:0] O_FRZ   = 8'b0000_0110;
  localparam logic [7:0] O_REL   = 8'b1101_0011;
  localparam logic [7:0] O_RELBR = 8'b1111_1011;
  localparam logic [7:0] O_RST   = 8'b0000_0000;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       memread;
    logic [4:0] idex_rt;
    logic       br;
    logic       mdu;
  } in_t;

  typedef struct {
    in_t        in;
    logic [7:0] exp;
    string      name;
  } vec_t;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [4:0] id_rs_i, id_rt_i, idex_rt_i;
  logic       id_uses_rt_i, idex_memread_i, ex_branch_taken_i, ex_mdu_i;
  logic       pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o;
  logic       idex_flush_o, exmem_flush_o, mdu_busy_o, mdu_done_o;
  logic [7:0] out_v;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int c_prev  = 0;

  always #5 clk_i = ~clk_i;

  hazard_ctrl_unit #(
    .MDU_LAT (MDU_LAT),
    .REG_W   (5)
  ) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .id_rs_i           (id_rs_i),
    .id_rt_i           (id_rt_i),
    .id_uses_rt_i      (id_uses_rt_i),
    .idex_memread_i    (idex_memread_i),
    .idex_rt_i         (idex_rt_i),
    .ex_branch_taken_i (ex_branch_taken_i),
    .ex_mdu_i          (ex_mdu_i),
    .pc_write_o        (pc_write_o),
    .ifid_write_o      (ifid_write_o),
    .ifid_flush_o      (ifid_flush_o),
    .idex_write_o      (idex_write_o),
    .idex_flush_o      (idex_flush_o),
    .exmem_flush_o     (exmem_flush_o),
    .mdu_busy_o        (mdu_busy_o),
    .mdu_done_o        (mdu_done_o)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stall_cnt_o  (perf_stall_cnt),
    .perf_flush_cnt_o  (perf_flush_cnt)
`endif
  );

  assign out_v = {pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o,
                  idex_flush_o, exmem_flush_o, mdu_busy_o, mdu_done_o};

  function automatic in_t mk(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                             input logic uses, input logic mr, input logic [4:0] xrt,
                             input logic br, input logic mdu);
    mk = {rst, rs, rt, uses, mr, xrt, br, mdu};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic apply(input in_t v);
    rst_i             = v.rst;
    id_rs_i           = v.rs;
    id_rt_i           = v.rt;
    id_uses_rt_i      = v.uses_rt;
    idex_memread_i    = v.memread;
    idex_rt_i         = v.idex_rt;
    ex_branch_taken_i = v.br;
    ex_mdu_i          = v.mdu;
  endtask

  // Drive one cycle's inputs after the falling edge and check the settled outputs
  task automatic step(input in_t v, input logic [7:0] exp, input string name);
    @(negedge clk_i);
    apply(v);
    #1;
    check(name, 32'(out_v), 32'(exp));
  endtask

  // Reference: track which EX cycle (1..MDU_LAT) the current MDU op is in
  task automatic model(input in_t v, output logic [7:0] e);
    int   c;
    logic lu;
    lu = v.memread && (v.idex_rt != 5'd0)
      && ((v.idex_rt == v.rs) || (v.uses_rt && (v.idex_rt == v.rt)));
    if (v.rst) begin
      e      = O_RST;
      c_prev = 0;
    end else begin
      if (c_prev > 0 && c_prev < int'(MDU_LAT)) c = c_prev + 1;
      else c = (!v.br && v.mdu) ? 1 : 0;
      if (c >= 1 && c < int'(MDU_LAT)) begin
        e = (c >= 2) ? O_FRZ : O_ENT;
      end else begin
        e = v.br ? O_BR : (lu ? O_LU : O_DEF);
        if (c == int'(MDU_LAT)) e[1:0] = 2'b11;
      end
      c_prev = (c == int'(MDU_LAT)) ? 0 : c;
    end
  endtask

  vec_t vecs[10];

  initial begin
    in_t        idle, mdu, mdu_br, rnd;
    logic [7:0] e;

    idle   = mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0);
    mdu    = mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1);
    mdu_br = mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 1);
    apply(mk(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0));

    vecs[0] = '{mk(1, 5'd8, 5'd0, 0, 1, 5'd8, 1, 1), O_RST, "reset_all_zero"};
    vecs[1] = '{idle,                                 O_DEF, "idle_default"};
    vecs[2] = '{mk(0, 5'd8, 5'd1, 0, 1, 5'd8, 0, 0), O_LU,  "load_use_rs"};
    vecs[3] = '{mk(0, 5'd8, 5'd1, 0, 1, 5'd7, 0, 0), O_DEF, "load_use_cleared"};
    vecs[4] = '{mk(0, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0), O_DEF, "zero_reg_no_stall"};
    vecs[5] = '{mk(0, 5'd3, 5'd9, 0, 1, 5'd9, 0, 0), O_DEF, "rt_unused_no_stall"};
    vecs[6] = '{mk(0, 5'd3, 5'd9, 1, 1, 5'd9, 0, 0), O_LU,  "load_use_rt"};
    vecs[7] = '{mk(0, 5'd9, 5'd9, 1, 0, 5'd9, 0, 0), O_DEF, "no_memread_no_stall"};
    vecs[8] = '{mk(0, 5'd8, 5'd8, 1, 1, 5'd8, 1, 0), O_BR,  "branch_over_load_use"};
    vecs[9] = '{mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0), O_BR,  "branch_alone"};

    for (int i = 0; i < 10; i++) step(vecs[i].in, vecs[i].exp, vecs[i].name);

    // MDU held for a full op, then a back-to-back op released alongside a taken branch
    step(mdu,    O_ENT,   "mdu1_c1_enter");
    step(mdu_br, O_FRZ,   "mdu1_c2_branch_ignored");
    step(mdu,    O_FRZ,   "mdu1_c3_frozen");
    step(mdu,    O_REL,   "mdu1_c4_release");
    step(mdu,    O_ENT,   "mdu2_enter");
    step(mdu,    O_FRZ,   "mdu2_c2_frozen");
    step(mdu,    O_FRZ,   "mdu2_c3_frozen");
    step(mdu_br, O_RELBR, "mdu2_release_branch");
    step(idle,   O_DEF,   "after_mdu_default");

    // Reset aborts an MDU wait with no done pulse afterwards
    step(mdu,                                 O_ENT, "rmdu_enter");
    step(mk(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1), O_RST, "rst_mid_mdu");
    step(idle,                                O_DEF, "after_rst_no_done");
    step(idle,                                O_DEF, "after_rst_idle");

`ifdef HAZARD_PERF_EN
    step(mk(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0), O_RST, "perf_reset");
    step(mk(0, 5'd8, 5'd1, 0, 1, 5'd8, 0, 0), O_LU,  "perf_lu1");
    step(mk(0, 5'd5, 5'd1, 0, 1, 5'd5, 0, 0), O_LU,  "perf_lu2");
    step(mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0), O_BR,  "perf_branch");
    step(mdu, O_ENT, "perf_mdu_c1");
    step(idle, O_FRZ, "perf_mdu_c2");
    step(idle, O_FRZ, "perf_mdu_c3");
    step(idle, O_REL, "perf_mdu_c4");
    step(idle, O_DEF, "perf_idle");
    check("perf_stall_cnt", perf_stall_cnt, 32'd5);
    check("perf_flush_cnt", perf_flush_cnt, 32'd1);
`endif

    // Randomized run against the reference model, starting from reset
    rnd = mk(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0);
    model(rnd, e);
    step(rnd, e, "rand_reset");
    for (int i = 0; i < 3000; i++) begin
      rnd.rst     = ($urandom_range(0, 63) == 0);
      rnd.rs      = 5'($urandom_range(0, 3));
      rnd.rt      = 5'($urandom_range(0, 3));
      rnd.uses_rt = 1'($urandom_range(0, 1));
      rnd.memread = 1'($urandom_range(0, 1));
      rnd.idex_rt = 5'($urandom_range(0, 3));
      rnd.br      = ($urandom_range(0, 7) == 0);
      rnd.mdu     = ($urandom_range(0, 5) == 0);
      model(rnd, e);
      step(rnd, e, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Pipeline hazard and stall sequencer for the 5-stage CPU.
- Drives the write-enable and flush controls of the PC and the IF/ID, ID/EX and EX/MEM pipeline registers.
- Resolves load-use stalls and taken-branch redirects.
- Freezes the front of the pipeline while a multi-cycle multiply/divide (MDU) op occupies EX.

Parameters:
MDU_LAT, 4, number of cycles an MDU op occupies EX (legal range >= 2)
REG_W, 5, register-specifier width
CNT_W, $clog2(MDU_LAT), width of the MDU wait counter

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  synchronous reset, active-high
id_rs_i  input  REG_W  rs specifier of the instruction in ID
id_rt_i  input  REG_W  rt specifier of the instruction in ID
id_uses_rt_i  input  1  ID instruction reads rt as a source
idex_memread_i  input  1  instruction in EX is a load
idex_rt_i  input  REG_W  destination rt of the load in EX
ex_branch_taken_i  input  1  branch/jump resolved taken in EX
ex_mdu_i  input  1  instruction in EX is an MDU op
pc_write_o  output  1  PC update enable
ifid_write_o  output  1  IF/ID write enable
ifid_flush_o  output  1  IF/ID flush (bubble)
idex_write_o  output  1  ID/EX write enable
idex_flush_o  output  1  ID/EX flush (bubble)
exmem_flush_o  output  1  EX/MEM flush (bubble)
mdu_busy_o  output  1  controller is in MDU_WAIT
mdu_done_o  output  1  one-cycle pulse on the final EX cycle of an MDU op

Behaviour:
- Clock and reset: one clock clk_i; rst_i is synchronous and active-high.
- Reset: state <= RUN, cnt <= 0.
- While rst_i=1, every output is 0, overriding all other logic.
- Outputs are combinational from the registered state/cnt and the current inputs. The only registered elements are state and cnt.
- Default outputs (no hazard): pc_write=ifid_write=idex_write=1; all flushes=0; mdu_busy=0; mdu_done=0.

- State RUN, priority high to low:
  1. ex_branch_taken_i=1: ifid_flush=1, idex_flush=1, pc_write=1. Any load-use hazard in the same cycle is ignored, because the flushed ID instruction is dead.
  2. ex_mdu_i=1: pc_write=ifid_write=idex_write=0, exmem_flush=1. Next state is MDU_WAIT with cnt <= MDU_LAT-2.
  3. Load-use hazard: idex_memread_i=1, idex_rt_i!=0, and either idex_rt_i==id_rs_i, or id_uses_rt_i=1 with idex_rt_i==id_rt_i. Response: pc_write=0, ifid_write=0, idex_flush=1 for exactly one cycle; state stays RUN.
  4. Otherwise: default outputs.

- State MDU_WAIT, mdu_busy=1:
  - cnt!=0: pc_write=ifid_write=idex_write=0, exmem_flush=1; cnt decrements.
  - cnt==0: release cycle. mdu_done=1 and next state is RUN. Outputs follow RUN rules 1, 3 and 4; ex_mdu_i is ignored, so the held op does not re-trigger.
- The MDU op is in EX for exactly MDU_LAT cycles, and the front end is frozen for MDU_LAT-1 cycles.
- Back-to-back MDU ops: the second op enters EX after the release cycle and re-enters MDU_WAIT from RUN normally.
- ex_branch_taken_i has no effect in MDU_WAIT while cnt!=0.
- Reset during MDU_WAIT aborts the wait: RUN, cnt=0, no mdu_done pulse.
- MDU_LAT=2: cnt loads 0, giving one frozen cycle followed by the release cycle.

Optional Feature:
HAZARD_PERF_EN
- Defined: adds outputs perf_stall_cnt_o[31:0] and perf_flush_cnt_o[31:0].
  - perf_stall_cnt_o increments on each cycle with pc_write_o=0 and rst_i=0.
  - perf_flush_cnt_o increments on each cycle with ifid_flush_o=1.
  - Both counters clear on reset and wrap modulo 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package hazard_pkg holds:
  - state enum: RUN=1'b0, MDU_WAIT=1'b1
  - REG_W default
  - MDU_LAT default
  - zero-register constant ZERO_REG=5'd0
- Sub-module mdu_wait_counter (load, decrement, zero flag) is natural. The hazard priority decode stays in the top module.

Test Plan:
- Load-use: idex_memread=1, idex_rt=8, id_rs=8 -> one cycle with pc_write=0, ifid_write=0, idex_flush=1; the next cycle with the hazard cleared shows default outputs.
- Register zero: idex_memread=1, idex_rt=0, id_rs=0 -> no stall; also idex_rt=9, id_rt=9, id_uses_rt=0 -> no stall.
- Branch vs load-use: ex_branch_taken=1 with a load-use hazard present -> ifid_flush=1, idex_flush=1, pc_write=1, ifid_write=1.
- MDU, MDU_LAT=4:
  - ex_mdu_i held at 1 -> pc_write=0 for 3 cycles.
  - mdu_busy=1 in cycles 2-4; mdu_done=1 in cycle 4 with pc_write=1.
  - A second MDU op in cycle 5 re-enters MDU_WAIT.
- Reset mid-MDU: rst_i=1 on the second frozen cycle -> all outputs 0 that cycle; the next cycle is RUN defaults with no mdu_done pulse.
- HAZARD_PERF_EN: 2 load-use stalls, 1 branch and 1 MDU op (MDU_LAT=4) -> perf_stall_cnt=5, perf_flush_cnt=1.
